// File: rtl/stim_gen.sv
// stim_gen: programmable multi-channel square-wave generator plus an ordered reset-release sequencer.
// Define STIM_GEN_PHASE_EN to add the CH_SYNC input that realigns every channel to the start of its LOW phase.
module stim_gen #(
   parameter int                 NUM_CH    = 2,
   parameter int                 CNT_W     = 16,
   parameter int                 NUM_RST   = 2,
   parameter int                 DLY_W     = 16,
   parameter logic [NUM_RST-1:0] RST_LEVEL = '0
) (
   input  logic                     SYSCLK,
   input  logic                     RESET,
   input  logic                     EN,
`ifdef STIM_GEN_PHASE_EN
   input  logic                     CH_SYNC,
`endif
   input  logic [NUM_CH*CNT_W-1:0]  CH_HI,
   input  logic [NUM_CH*CNT_W-1:0]  CH_LO,
   input  logic [NUM_CH-1:0]        CH_LOAD,
   input  logic [NUM_RST*DLY_W-1:0] RST_DLY,
   output logic [NUM_CH-1:0]        CLK_OUT,
   output logic [NUM_RST-1:0]       RST_OUT,
   output logic                     SEQ_DONE
);

   localparam int IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
   localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(NUM_RST - 1);

   typedef enum logic {
      CH_LOW  = 1'b0,
      CH_HIGH = 1'b1
   } ch_state_t;

   typedef enum logic [1:0] {
      S_HOLD  = 2'd0,
      S_STAGE = 2'd1,
      S_DONE  = 2'd2
   } seq_state_t;

   logic ch_sync;

`ifdef STIM_GEN_PHASE_EN
   assign ch_sync = CH_SYNC;
`else
   assign ch_sync = 1'b0;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ch_state_t        state_q;
      ch_state_t        state_d;
      logic [CNT_W-1:0] hi_in;
      logic [CNT_W-1:0] lo_in;
      logic [CNT_W-1:0] hi_q;
      logic [CNT_W-1:0] lo_q;
      logic [CNT_W-1:0] hi_eff;
      logic [CNT_W-1:0] lo_eff;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             clk_bit;

      assign hi_in = CH_HI[i*CNT_W +: CNT_W];
      assign lo_in = CH_LO[i*CNT_W +: CNT_W];

      // A load strobe is already visible to a reload in the same cycle; zero lengths clamp to one cycle.
      always_comb begin
         hi_eff = hi_q;
         lo_eff = lo_q;
         if (CH_LOAD[i]) begin
            hi_eff = (hi_in == '0) ? CNT_W'(1) : hi_in;
            lo_eff = (lo_in == '0) ? CNT_W'(1) : lo_in;
         end
      end

      always_ff @(posedge SYSCLK) begin
         if (RESET) begin
            state_q <= CH_LOW;
            hi_q    <= CNT_W'(1);
            lo_q    <= CNT_W'(1);
            cnt_q   <= CNT_W'(1);
         end else begin
            state_q <= state_d;
            hi_q    <= hi_eff;
            lo_q    <= lo_eff;
            cnt_q   <= cnt_d;
         end
      end

      // Shadows only enter the counter at a phase boundary, so a running phase is never cut short.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         if (ch_sync) begin
            state_d = CH_LOW;
            cnt_d   = lo_eff;
         end else if (EN) begin
            if (cnt_q <= CNT_W'(1)) begin
               if (state_q == CH_LOW) begin
                  state_d = CH_HIGH;
                  cnt_d   = hi_eff;
               end else begin
                  state_d = CH_LOW;
                  cnt_d   = lo_eff;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
      end

      always_comb begin
         clk_bit = (state_q == CH_HIGH);
      end

      assign CLK_OUT[i] = clk_bit;
   end

   seq_state_t       seq_q;
   seq_state_t       seq_d;
   logic [IDX_W-1:0] stage_q;
   logic [IDX_W-1:0] stage_d;
   logic [DLY_W-1:0] dly_cnt_q;
   logic [DLY_W-1:0] dly_cnt_d;
   logic [NUM_RST-1:0] rel_q;
   logic [NUM_RST-1:0] rel_d;
   logic [DLY_W-1:0] cur_dly;
   logic [DLY_W:0]   dly_cnt_inc;
   logic             stage_expired;

   always_comb begin
      cur_dly = '0;
      for (int j = 0; j < NUM_RST; j++) begin
         if (stage_q == IDX_W'(j)) begin
            cur_dly = RST_DLY[j*DLY_W +: DLY_W];
         end
      end
   end

   // Every stage spends at least one cycle, so a zero delay releases in the cycle after entry.
   assign dly_cnt_inc   = {1'b0, dly_cnt_q} + {{DLY_W{1'b0}}, 1'b1};
   assign stage_expired = (dly_cnt_inc >= {1'b0, cur_dly});

   always_ff @(posedge SYSCLK) begin
      if (RESET) begin
         seq_q     <= S_HOLD;
         stage_q   <= '0;
         dly_cnt_q <= '0;
         rel_q     <= '0;
      end else begin
         seq_q     <= seq_d;
         stage_q   <= stage_d;
         dly_cnt_q <= dly_cnt_d;
         rel_q     <= rel_d;
      end
   end

   always_comb begin
      seq_d     = seq_q;
      stage_d   = stage_q;
      dly_cnt_d = dly_cnt_q;
      rel_d     = rel_q;
      case (seq_q)
         S_HOLD: begin
            if (EN) begin
               seq_d     = S_STAGE;
               stage_d   = '0;
               dly_cnt_d = '0;
            end
         end
         S_STAGE: begin
            if (EN) begin
               if (stage_expired) begin
                  for (int j = 0; j < NUM_RST; j++) begin
                     if (stage_q == IDX_W'(j)) begin
                        rel_d[j] = 1'b1;
                     end
                  end
                  dly_cnt_d = '0;
                  if (stage_q == LAST_STAGE) begin
                     seq_d = S_DONE;
                  end else begin
                     stage_d = stage_q + IDX_W'(1);
                  end
               end else begin
                  dly_cnt_d = dly_cnt_q + DLY_W'(1);
               end
            end
         end
         S_DONE: begin
            seq_d = S_DONE;
         end
         default: begin
            seq_d = S_HOLD;
         end
      endcase
   end

   // Release flags only ever set, so a released reset stays released until RESET.
   always_comb begin
      RST_OUT  = rel_q ^ RST_LEVEL;
      SEQ_DONE = (seq_q == S_DONE);
   end

endmodule

// File: tb/tb_stim_gen.sv
// Testbench for stim_gen: directed scenarios push expected outputs into a scoreboard
// that a negedge monitor drains and compares in the cycle each expectation falls due.
module tb_stim_gen;

   localparam int NUM_CH  = 2;
   localparam int CNT_W   = 8;
   localparam int NUM_RST = 2;
   localparam int DLY_W   = 8;
   localparam logic [NUM_RST-1:0] RST_LEVEL = 2'b00;

   localparam int SIG_CLK0 = 0;
   localparam int SIG_CLK1 = 1;
   localparam int SIG_RST  = 2;
   localparam int SIG_DONE = 3;

   logic                     SYSCLK  = 1'b0;
   logic                     RESET   = 1'b1;
   logic                     EN      = 1'b0;
`ifdef STIM_GEN_PHASE_EN
   logic                     CH_SYNC = 1'b0;
`endif
   logic [NUM_CH*CNT_W-1:0]  CH_HI   = '0;
   logic [NUM_CH*CNT_W-1:0]  CH_LO   = '0;
   logic [NUM_CH-1:0]        CH_LOAD = '0;
   logic [NUM_RST*DLY_W-1:0] RST_DLY = '0;
   logic [NUM_CH-1:0]        CLK_OUT;
   logic [NUM_RST-1:0]       RST_OUT;
   logic                     SEQ_DONE;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int base     = 0;

   int         q_cyc[$];
   int         q_sig[$];
   logic [7:0] q_exp[$];
   string      q_name[$];

   logic [19:0] pat;

   stim_gen #(
      .NUM_CH   (NUM_CH),
      .CNT_W    (CNT_W),
      .NUM_RST  (NUM_RST),
      .DLY_W    (DLY_W),
      .RST_LEVEL(RST_LEVEL)
   ) dut (
      .SYSCLK  (SYSCLK),
      .RESET   (RESET),
      .EN      (EN),
`ifdef STIM_GEN_PHASE_EN
      .CH_SYNC (CH_SYNC),
`endif
      .CH_HI   (CH_HI),
      .CH_LO   (CH_LO),
      .CH_LOAD (CH_LOAD),
      .RST_DLY (RST_DLY),
      .CLK_OUT (CLK_OUT),
      .RST_OUT (RST_OUT),
      .SEQ_DONE(SEQ_DONE)
   );

   always #5 SYSCLK = ~SYSCLK;

   always @(posedge SYSCLK) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input int sig, input logic [7:0] exp, input string name, input int due);
      logic [7:0] act;
      case (sig)
         SIG_CLK0: act = {7'b0, CLK_OUT[0]};
         SIG_CLK1: act = {7'b0, CLK_OUT[1]};
         SIG_RST:  act = {6'b0, RST_OUT};
         default:  act = {7'b0, SEQ_DONE};
      endcase
      checks++;
      if (due != cyc) begin
         failures++;
         $display("[TB] FAIL %s: sampled at cycle %0d instead of due cycle %0d", name, cyc, due);
      end else if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: drains every expectation that has fallen due by this cycle.
   always @(negedge SYSCLK) begin
      for (int i = q_cyc.size() - 1; i >= 0; i--) begin
         if (q_cyc[i] <= cyc) begin
            checkOutput(q_sig[i], q_exp[i], q_name[i], q_cyc[i]);
            q_cyc.delete(i);
            q_sig.delete(i);
            q_exp.delete(i);
            q_name.delete(i);
         end
      end
   end

   task automatic expect_at(input int off, input int sig, input int val, input string name);
      q_cyc.push_back(base + off);
      q_sig.push_back(sig);
      q_exp.push_back(8'(val));
      q_name.push_back(name);
   endtask

   task automatic expect_seq(input int off, input int rst, input int done, input string name);
      expect_at(off, SIG_RST, rst, name);
      expect_at(off, SIG_DONE, done, name);
   endtask

   task automatic applyStimulus(input logic rst, input logic en, input logic [NUM_CH-1:0] load,
                                input int cycles);
      RESET   = rst;
      EN      = en;
      CH_LOAD = load;
      repeat (cycles) @(negedge SYSCLK);
   endtask

   task automatic set_ch(input int ch, input int hi, input int lo);
      CH_HI[ch*CNT_W +: CNT_W] = CNT_W'(hi);
      CH_LO[ch*CNT_W +: CNT_W] = CNT_W'(lo);
   endtask

   task automatic set_dly(input int stage, input int dly);
      RST_DLY[stage*DLY_W +: DLY_W] = DLY_W'(dly);
   endtask

   task automatic do_reset();
      base = cyc;
      expect_at(1, SIG_CLK0, 0, "reset_clk0");
      expect_at(1, SIG_CLK1, 0, "reset_clk1");
      expect_seq(1, int'(RST_LEVEL), 0, "reset_seq");
      applyStimulus(1'b1, 1'b0, '0, 2);
   endtask

   initial begin
      @(negedge SYSCLK);

      // Scenario 1: ch0 3/5, ch1 zero-high clamps to 1/2, resets released after 10 then 0 cycles.
      do_reset();
      set_ch(0, 3, 5);
      set_ch(1, 0, 2);
      set_dly(0, 10);
      set_dly(1, 0);
      base = cyc;
      for (int k = 1; k <= 17; k++) expect_at(k, SIG_CLK0, (((k - 1) % 8) < 3) ? 1 : 0, "ch0_hi3_lo5");
      for (int k = 1; k <= 9; k++) expect_at(k, SIG_CLK1, (((k - 1) % 3) == 0) ? 1 : 0, "ch1_hi0_lo2");
      expect_seq(10, 0, 0, "seq_before_rel0");
      expect_seq(11, 1, 0, "seq_rel0");
      expect_seq(12, 3, 1, "seq_rel1_done");
      expect_seq(17, 3, 1, "seq_done_holds");
      applyStimulus(1'b0, 1'b1, 2'b11, 1);
      applyStimulus(1'b0, 1'b1, 2'b00, 18);

      // Scenario 2: ch0 4/4, reload to 2/2 in mid-high takes effect only at the boundary.
      do_reset();
      set_ch(0, 4, 4);
      base = cyc;
      pat = 20'b1001_1001_1110_0001_1110;
      for (int k = 1; k <= 19; k++) expect_at(k, SIG_CLK0, pat[k] ? 1 : 0, "ch0_reload_4to2");
      applyStimulus(1'b0, 1'b1, 2'b01, 1);
      applyStimulus(1'b0, 1'b1, 2'b00, 9);
      set_ch(0, 2, 2);
      applyStimulus(1'b0, 1'b1, 2'b01, 1);
      applyStimulus(1'b0, 1'b1, 2'b00, 10);

      // Scenario 3: EN low for 7 cycles, 5 cycles into stage 0; everything freezes in place.
      do_reset();
      set_ch(0, 8, 2);
      set_dly(0, 10);
      set_dly(1, 0);
      base = cyc;
      expect_at(5, SIG_CLK0, 1, "freeze_ch0_pre");
      expect_at(6, SIG_CLK0, 1, "freeze_ch0_hold");
      expect_at(9, SIG_CLK0, 1, "freeze_ch0_hold");
      expect_at(12, SIG_CLK0, 1, "freeze_ch0_hold");
      expect_at(13, SIG_CLK0, 1, "freeze_ch0_resume");
      expect_at(15, SIG_CLK0, 1, "freeze_ch0_resume");
      expect_at(16, SIG_CLK0, 0, "freeze_ch0_fall");
      expect_at(17, SIG_CLK0, 0, "freeze_ch0_low");
      expect_at(18, SIG_CLK0, 1, "freeze_ch0_rise");
      expect_at(5, SIG_CLK1, 1, "freeze_ch1_pre");
      expect_at(8, SIG_CLK1, 1, "freeze_ch1_hold");
      expect_at(12, SIG_CLK1, 1, "freeze_ch1_hold");
      expect_at(13, SIG_CLK1, 0, "freeze_ch1_resume");
      expect_at(14, SIG_CLK1, 1, "freeze_ch1_resume");
      expect_seq(11, 0, 0, "pause_no_early_rel");
      expect_seq(17, 0, 0, "pause_before_rel0");
      expect_seq(18, 1, 0, "pause_rel0");
      expect_seq(19, 3, 1, "pause_rel1_done");
      applyStimulus(1'b0, 1'b1, 2'b01, 1);
      applyStimulus(1'b0, 1'b1, 2'b00, 4);
      applyStimulus(1'b0, 1'b0, 2'b00, 7);
      applyStimulus(1'b0, 1'b1, 2'b00, 9);

      // Scenario 4: RESET during stage 1 reasserts everything, then the sequence restarts.
      do_reset();
      set_ch(0, 8, 2);
      set_dly(0, 3);
      set_dly(1, 6);
      base = cyc;
      expect_seq(4, 1, 0, "midrst_rel0");
      expect_at(5, SIG_CLK0, 1, "midrst_ch0_high");
      expect_seq(5, 1, 0, "midrst_stage1");
      expect_at(6, SIG_CLK0, 0, "midrst_clk0");
      expect_at(6, SIG_CLK1, 0, "midrst_clk1");
      expect_seq(6, 0, 0, "midrst_reasserted");
      expect_at(7, SIG_CLK0, 1, "midrst_shadow_reset");
      expect_at(8, SIG_CLK0, 0, "midrst_shadow_reset");
      expect_seq(9, 0, 0, "restart_hold");
      expect_seq(10, 1, 0, "restart_rel0");
      expect_seq(15, 1, 0, "restart_stage1");
      expect_seq(16, 3, 1, "restart_done");
      expect_seq(20, 3, 1, "restart_done_holds");
      applyStimulus(1'b0, 1'b1, 2'b01, 1);
      applyStimulus(1'b0, 1'b1, 2'b00, 4);
      applyStimulus(1'b1, 1'b1, 2'b00, 1);
      applyStimulus(1'b0, 1'b1, 2'b00, 16);

`ifdef STIM_GEN_PHASE_EN
      // Scenario 5: CH_SYNC realigns ch0 3/3 and ch1 5/5 to the start of their LOW phases.
      do_reset();
      set_ch(0, 3, 3);
      set_ch(1, 5, 5);
      base = cyc;
      expect_at(2, SIG_CLK0, 0, "sync_ch0_low");
      expect_at(2, SIG_CLK1, 0, "sync_ch1_low");
      expect_at(4, SIG_CLK0, 0, "sync_ch0_low");
      expect_at(4, SIG_CLK1, 0, "sync_ch1_low");
      expect_at(5, SIG_CLK0, 1, "sync_ch0_rise");
      expect_at(6, SIG_CLK1, 0, "sync_ch1_low");
      expect_at(7, SIG_CLK0, 1, "sync_ch0_high");
      expect_at(7, SIG_CLK1, 1, "sync_ch1_rise");
      expect_at(8, SIG_CLK0, 0, "sync_ch0_fall");
      applyStimulus(1'b0, 1'b1, 2'b11, 1);
      CH_SYNC = 1'b1;
      applyStimulus(1'b0, 1'b1, 2'b00, 1);
      CH_SYNC = 1'b0;
      applyStimulus(1'b0, 1'b1, 2'b00, 8);
`endif

      repeat (3) @(negedge SYSCLK);
      checks++;
      if (q_cyc.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", q_cyc.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
